// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package instr_fetch_unit_pkg;

    localparam int PC_W = 32;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_ifid_reg.sv
// IF/ID output register: flush beats load, otherwise the contents hold.
module instr_fetch_unit_ifid_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              valid,
    output logic [DATA_W-1:0] inst,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus4
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_plus4_q, pc_plus4_d;

    always_comb begin
        valid_d    = valid_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d    = 1'b1;
            inst_d     = in_inst;
            pc_d       = in_pc;
            pc_plus4_d = in_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            inst_q     <= DATA_W'(NOP_INST);
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid    = valid_q;
    assign inst     = inst_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational IM and feeds
// decode through a valid/ready IF/ID register; handles redirects and EBREAK.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 32,
    parameter logic [PC_W-1:0]   RESET_PC  = 32'h0000_0000,
    parameter logic [DATA_W-1:0] HALT_INST = DATA_W'(EBREAK_INST)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addressIM,
    input  logic [DATA_W-1:0] inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc_plus4,
    output logic              halted,
    output logic              fault
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;
    logic            ifid_load, ifid_flush;
    logic            load_ok, pc_out_of_range;

    assign addressIM       = pc_q[ADDR_W+1:2];
    assign load_ok         = !out_valid || out_ready;
    assign pc_out_of_range = (pc_q >> (ADDR_W + 2)) != '0;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;

        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (load_ok) begin
                    if (pc_out_of_range) begin
                        // Any held instruction was consumed this cycle, so clearing is safe.
                        ifid_flush = 1'b1;
                        fault_d    = 1'b1;
                        halted_d   = 1'b1;
                        state_d    = HALT;
                    end else begin
                        ifid_load = 1'b1;
                        if (inst == HALT_INST) begin
                            halted_d = 1'b1;
                            state_d  = HALT;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
            end
            HALT: begin
                if (out_valid && out_ready) ifid_flush = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything decided above, including a same-cycle load.
        if (redirect_valid && state_q != IDLE) begin
            ifid_load  = 1'b0;
            ifid_flush = 1'b1;
            if (redirect_pc[1:0] != 2'b00) begin
                pc_d     = pc_q;
                fault_d  = 1'b1;
                halted_d = 1'b1;
                state_d  = HALT;
            end else begin
                pc_d     = redirect_pc;
                halted_d = 1'b0;
                state_d  = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    instr_fetch_unit_ifid_reg #(
        .DATA_W(DATA_W)
    ) u_ifid_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .in_inst (inst),
        .in_pc   (pc_q),
        .valid   (out_valid),
        .inst    (out_inst),
        .pc      (out_pc),
        .pc_plus4(out_pc_plus4)
    );

    assign halted = halted_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a behavioural combinational IM.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] addressIM;
    logic [DATA_W-1:0] inst;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_inst;
    logic [31:0]       out_pc;
    logic [31:0]       out_pc_plus4;
    logic              halted;
    logic              fault;

    logic [31:0] im [32];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign inst = im[addressIM];

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (32'h0000_0000),
        .HALT_INST(EBREAK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .addressIM     (addressIM),
        .inst          (inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_pc_plus4  (out_pc_plus4),
        .halted        (halted),
        .fault         (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        logic [4:0] w;
        w      = pc[6:2];
        e.pc   = pc;
        e.inst = im[w];
        sb.push_back(e);
    endtask

    // Score a transfer happening at the coming edge, then advance one cycle.
    task automatic step();
        exp_t e;
        if (out_valid && out_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_inst", out_inst, e.inst);
                check("out_pc_plus4", out_pc_plus4, e.pc + 32'd4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_inst"}, out_inst, NOP);
        check({tag, "_pc"}, out_pc, 32'd0);
        check({tag, "_pc4"}, out_pc_plus4, 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_addr"}, 32'(addressIM), 32'd0);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;
        step();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_addr", 32'(addressIM), 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 32; i++) im[i] = 32'hA500_0000 | 32'(i << 8) | 32'h13;

        // Sequential fetch, stall, redirect
        do_reset();
        for (int i = 0; i < 5; i++) push(32'(i * 4));
        step();
        check("addr_1", 32'(addressIM), 32'd1);
        step();
        check("addr_2", 32'(addressIM), 32'd2);
        step();
        check("addr_3", 32'(addressIM), 32'd3);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", out_pc, 32'd8);
            check("stall_inst", out_inst, im[2]);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_addr", 32'(addressIM), 32'd3);
        end
        out_ready = 1'b1;
        step();
        check("addr_4", 32'(addressIM), 32'd4);
        step();
        step();
        check("pre_redir_pc", out_pc, 32'd20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_addr", 32'(addressIM), 32'd8);
        push(32'h20);
        step();
        step();
        check("sb_drained_1", 32'(sb.size()), 32'd0);

        // EBREAK at word 3, then restart by redirect
        im[3] = EBREAK;
        do_reset();
        for (int i = 0; i < 4; i++) push(32'(i * 4));
        step();
        step();
        step();
        step();
        check("ebreak_pc", out_pc, 32'd12);
        check("ebreak_halted", 32'(halted), 32'd1);
        step();
        check("halt_valid", 32'(out_valid), 32'd0);
        check("halt_addr", 32'(addressIM), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_hold_valid", 32'(out_valid), 32'd0);
            check("halt_hold_halted", 32'(halted), 32'd1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_addr", 32'(addressIM), 32'd0);
        push(32'h0);
        push(32'h4);
        step();
        step();
        step();
        check("restart_pc", out_pc, 32'd8);
        im[3] = 32'hA500_0313;

        // Misaligned redirect, sticky fault, async reset
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        step();
        redirect_valid = 1'b0;
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_halted", 32'(halted), 32'd1);
        check("mis_valid", 32'(out_valid), 32'd0);
        check("mis_addr", 32'(addressIM), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fault_sticky", 32'(fault), 32'd1);
            check("fault_valid", 32'(out_valid), 32'd0);
        end
        #3;
        reset = 1'b1;
        #1;
        check_reset_state("async");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Run off the end of IM
        do_reset();
        for (int i = 0; i < 32; i++) push(32'(i * 4));
        step();
        for (int i = 0; i < 32; i++) begin
            check("wrap_fault_early", 32'(fault), 32'd0);
            step();
        end
        check("wrap_fault", 32'(fault), 32'd1);
        check("wrap_halted", 32'(halted), 32'd1);
        check("wrap_valid", 32'(out_valid), 32'd0);
        step();
        check("wrap_fault_hold", 32'(fault), 32'd1);
        check("wrap_valid_hold", 32'(out_valid), 32'd0);
        check("sb_drained_2", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
